// File: rtl/spi_target_core.sv
// ---------------------------------------------------------------------------
// spi_target_core: SPI target (modes 0-3) with FWFT RX/TX FIFOs, sticky errors
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_target_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic            w_empty;
  logic            w_full;
  logic            w_wr_en;
  logic            w_rd_en;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_depth);
  assign w_rd_en = pop & ~w_empty;
  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign w_wr_en = push & (~w_full | w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_level <= r_level + (c_aw+1)'(1);
      end else if (!w_wr_en && w_rd_en) begin
        r_level <= r_level - (c_aw+1)'(1);
      end
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign level = r_level;
endmodule

module spi_target_core #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] TX_IDLE    = '1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          sclk_i,
  input  logic                          mosi_i,
  input  logic                          ss_n_i,
  output logic                          miso_o,
  output logic                          miso_oe_o,
  input  logic                          cpol_i,
  input  logic                          cpha_i,
  input  logic                          ie_i,
  output logic [DATA_W-1:0]             rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic [2:0]                    err_o,
  input  logic [2:0]                    err_clr_i,
  output logic                          irq_o
);
  localparam int c_cnt_w = $clog2(DATA_W);
  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);
  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_active = 1'b1;

  logic [1:0]         r_sclk_sync;
  logic [1:0]         r_mosi_sync;
  logic [1:0]         r_ss_sync;
  logic [1:0]         r_sync_vld;
  logic               r_sclk_d;
  logic               r_ss_d;
  logic               r_armed;
  logic [0:0]         r_state;
  logic               r_cpol;
  logic               r_cpha;
  logic               r_skip_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic [DATA_W-2:0]  r_rx_sr;
  logic [DATA_W-1:0]  r_tx_sr;
  logic [2:0]         r_err;
  logic               r_irq;

  logic               w_sclk;
  logic               w_mosi;
  logic               w_ss;
  logic               w_rise;
  logic               w_fall;
  logic               w_lead;
  logic               w_trail;
  logic               w_frame_start;
  logic               w_frame_end;
  logic               w_active;
  logic               w_sample;
  logic               w_shift;
  logic               w_word_done;
  logic               w_tx_load;
  logic [DATA_W-1:0]  w_rx_word;
  logic [DATA_W-1:0]  w_tx_head;
  logic [DATA_W-1:0]  w_load_word;
  logic [c_lvl_w-1:0] w_rx_level;
  logic [c_lvl_w-1:0] w_tx_level;
  logic               w_tx_empty;
  logic               w_rx_full;
  logic               w_rx_pop;
  logic [2:0]         w_err_set;

  assign w_sclk = r_sclk_sync[1];
  assign w_mosi = r_mosi_sync[1];
  assign w_ss   = r_ss_sync[1];

  // r_armed requires a genuine high ss_n sample after reset before any frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_ss_sync   <= 2'b11;
      r_sync_vld  <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk_i};
      r_mosi_sync <= {r_mosi_sync[0], mosi_i};
      r_ss_sync   <= {r_ss_sync[0], ss_n_i};
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      if (r_sync_vld[1] && w_ss) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rise        = w_sclk & ~r_sclk_d;
  assign w_fall        = ~w_sclk & r_sclk_d;
  assign w_lead        = r_cpol ? w_fall : w_rise;
  assign w_trail       = r_cpol ? w_rise : w_fall;
  assign w_frame_start = (r_state == c_st_idle) & r_armed & r_ss_d & ~w_ss;
  assign w_frame_end   = (r_state == c_st_active) & ~r_ss_d & w_ss;
  assign w_active      = (r_state == c_st_active) & ~w_frame_end;
  assign w_sample      = w_active & (r_cpha ? w_trail : w_lead);
  assign w_shift       = w_active & (r_cpha ? w_lead : w_trail);
  assign w_word_done   = w_sample & (r_cnt == c_last_bit);
  assign w_rx_word     = {r_rx_sr, w_mosi};
  assign w_tx_load     = w_frame_start | w_word_done;
  assign w_tx_empty    = (w_tx_level == '0);
  assign w_load_word   = w_tx_empty ? TX_IDLE : w_tx_head;

  // The shift edge right after any word load keeps the MSB in place: for
  // CPHA=0 it is the tail of the finished word, for CPHA=1 the new word's lead.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= c_st_idle;
      r_cpol       <= 1'b0;
      r_cpha       <= 1'b0;
      r_skip_shift <= 1'b0;
      r_cnt        <= '0;
      r_rx_sr      <= '0;
      r_tx_sr      <= '0;
    end else if (w_frame_start) begin
      r_state      <= c_st_active;
      r_cpol       <= cpol_i;
      r_cpha       <= cpha_i;
      r_skip_shift <= cpha_i;
      r_cnt        <= '0;
      r_rx_sr      <= '0;
      r_tx_sr      <= w_load_word;
    end else if (w_frame_end) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_tx_sr      <= '0;
    end else begin
      if (w_sample) begin
        r_rx_sr <= w_rx_word[DATA_W-2:0];
        r_cnt   <= w_word_done ? '0 : r_cnt + c_cnt_w'(1);
      end
      if (w_word_done) begin
        r_tx_sr      <= w_load_word;
        r_skip_shift <= 1'b1;
      end else if (w_shift) begin
        if (r_skip_shift) begin
          r_skip_shift <= 1'b0;
        end else begin
          r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  spi_target_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (w_word_done),
    .push_data (w_rx_word),
    .pop       (w_rx_pop),
    .head      (rx_data_o),
    .level     (w_rx_level)
  );

  spi_target_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (tx_valid_i & tx_ready_o),
    .push_data (tx_data_i),
    .pop       (w_tx_load),
    .head      (w_tx_head),
    .level     (w_tx_level)
  );

  assign rx_valid_o = (w_rx_level != '0);
  assign rx_level_o = w_rx_level;
  assign tx_ready_o = (w_tx_level != c_depth);
  assign w_rx_full  = (w_rx_level == c_depth);
  assign w_rx_pop   = rx_valid_o & rx_ready_i;

  assign w_err_set = {w_frame_end & (r_cnt != '0),
                      w_tx_load & w_tx_empty,
                      w_word_done & w_rx_full & ~w_rx_pop};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_err <= 3'b000;
      r_irq <= 1'b0;
    end else begin
      r_err <= (r_err & ~err_clr_i) | w_err_set;
      r_irq <= ie_i & (rx_valid_o | (|r_err));
    end
  end

  assign err_o     = r_err;
  assign irq_o     = r_irq;
  assign miso_oe_o = (r_state == c_st_active);
  assign miso_o    = (r_state == c_st_active) & r_tx_sr[DATA_W-1];
endmodule

`default_nettype wire

// File: tb/tb_spi_target_core.sv
// ---------------------------------------------------------------------------
// tb_spi_target_core: randomized SPI master against a queue-based reference
// Revision: 1.1
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_target_core;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int HALF  = 8;

    logic             sys_clk;
    logic             sys_rst;
    logic             sclk_i;
    logic             mosi_i;
    logic             ss_n_i;
    logic             miso_o;
    logic             miso_oe_o;
    logic             cpol_i;
    logic             cpha_i;
    logic             ie_i;
    logic [DW-1:0]    rx_data_o;
    logic             rx_valid_o;
    logic             rx_ready_i;
    logic [DW-1:0]    tx_data_i;
    logic             tx_valid_i;
    logic             tx_ready_o;
    logic [LVL_W-1:0] rx_level_o;
    logic [2:0]       err_o;
    logic [2:0]       err_clr_i;
    logic             irq_o;

    spi_target_core #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sclk_i     (sclk_i),
        .mosi_i     (mosi_i),
        .ss_n_i     (ss_n_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .ie_i       (ie_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_level_o (rx_level_o),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i),
        .irq_o      (irq_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    logic [2:0]    err_m;
    logic [DW-1:0] mosi_words[8];

    function automatic logic [DW-1:0] model_load();
        if (tx_q.size() > 0) return tx_q.pop_front();
        err_m[1] = 1'b1;
        return {DW{1'b1}};
    endfunction

    function automatic void model_rx_push(input logic [DW-1:0] w);
        if (rx_q.size() < DEPTH) rx_q.push_back(w);
        else err_m[0] = 1'b1;
    endfunction

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        err_m = 3'b000;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        logic exp_rdy;
        exp_rdy = (tx_q.size() < DEPTH);
        @(negedge sys_clk);
        checks++;
        if (tx_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL tx_ready: got %b expected %b", tx_ready_o, exp_rdy);
        end
        tx_data_i  = w;
        tx_valid_i = 1'b1;
        @(negedge sys_clk);
        tx_valid_i = 1'b0;
        if (exp_rdy) tx_q.push_back(w);
    endtask

    task automatic spi_frame(input bit cpol, input bit cpha, input int nbits);
        logic [DW-1:0] got;
        logic [DW-1:0] exp_cur;
        int w;
        int bi;
        cpol_i = cpol;
        cpha_i = cpha;
        sclk_i = cpol;
        repeat (HALF) @(negedge sys_clk);
        exp_cur = model_load();
        ss_n_i = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        checks++;
        if (miso_oe_o !== 1'b1) begin
            errors++;
            $display("FAIL miso_oe_active: got %b expected 1", miso_oe_o);
        end
        got = '0;
        for (int b = 0; b < nbits; b++) begin
            w  = b / DW;
            bi = DW - 1 - (b % DW);
            if (!cpha) begin
                mosi_i = mosi_words[w][bi];
                repeat (HALF) @(negedge sys_clk);
                got[bi] = miso_o;
                sclk_i = ~sclk_i;
                repeat (HALF) @(negedge sys_clk);
                sclk_i = ~sclk_i;
            end else begin
                sclk_i = ~sclk_i;
                mosi_i = mosi_words[w][bi];
                repeat (HALF) @(negedge sys_clk);
                got[bi] = miso_o;
                sclk_i = ~sclk_i;
                repeat (HALF) @(negedge sys_clk);
            end
            if (bi == 0) begin
                checks++;
                if (got !== exp_cur) begin
                    errors++;
                    $display("FAIL miso_word%0d mode%0d: got %h expected %h", w, {cpol, cpha}, got, exp_cur);
                end
                model_rx_push(mosi_words[w]);
                exp_cur = model_load();
            end
        end
        if (!cpha) repeat (HALF) @(negedge sys_clk);
        ss_n_i = 1'b1;
        mosi_i = 1'b0;
        if (nbits % DW != 0) err_m[2] = 1'b1;
        repeat (8) @(negedge sys_clk);
        checks++;
        if (miso_oe_o !== 1'b0 || miso_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got oe=%b miso=%b expected 0 0", miso_oe_o, miso_o);
        end
    endtask

    task automatic drain_rx(input string name);
        checks++;
        if (rx_level_o !== LVL_W'(rx_q.size())) begin
            errors++;
            $display("FAIL %s rx_level: got %0d expected %0d", name, rx_level_o, rx_q.size());
        end
        while (rx_q.size() > 0) begin
            checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== rx_q[0]) begin
                errors++;
                $display("FAIL %s rx_data: got v=%b %h expected v=1 %h", name, rx_valid_o, rx_data_o, rx_q[0]);
            end
            rx_ready_i = 1'b1;
            @(negedge sys_clk);
            rx_ready_i = 1'b0;
            void'(rx_q.pop_front());
        end
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rx_empty: got valid %b expected 0", name, rx_valid_o);
        end
    endtask

    task automatic check_err(input string name, input logic [2:0] clr);
        checks++;
        if (err_o !== err_m) begin
            errors++;
            $display("FAIL %s err_o: got %b expected %b", name, err_o, err_m);
        end
        err_clr_i = clr;
        @(negedge sys_clk);
        err_clr_i = 3'b000;
        err_m = err_m & ~clr;
        @(negedge sys_clk);
        checks++;
        if (err_o !== err_m) begin
            errors++;
            $display("FAIL %s err_after_clr: got %b expected %b", name, err_o, err_m);
        end
    endtask

    task automatic check_irq(input string name);
        logic exp_irq;
        exp_irq = ie_i & ((rx_q.size() != 0) | (|err_m));
        checks++;
        if (irq_o !== exp_irq) begin
            errors++;
            $display("FAIL %s irq: got %b expected %b", name, irq_o, exp_irq);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || rx_valid_o !== 1'b0 || tx_ready_o !== 1'b1 ||
            rx_level_o !== '0 || err_o !== 3'b000 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got miso=%b oe=%b rxv=%b txr=%b lvl=%0d err=%b irq=%b expected 0 0 0 1 0 000 0",
                     miso_o, miso_oe_o, rx_valid_o, tx_ready_o, rx_level_o, err_o, irq_o);
        end
    endtask

    task automatic test_mode0();
        push_tx(8'hA5);
        mosi_words[0] = 8'h3C;
        spi_frame(1'b0, 1'b0, 8);
        checks++;
        if (rx_data_o !== 8'h3C || rx_level_o !== LVL_W'(1)) begin
            errors++;
            $display("FAIL mode0_rx: got %h lvl %0d expected 3c lvl 1", rx_data_o, rx_level_o);
        end
        drain_rx("mode0");
        check_err("mode0", 3'b111);
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            push_tx(8'h81);
            push_tx(8'h7E);
            mosi_words[0] = 8'h55;
            mosi_words[1] = 8'hAA;
            spi_frame(m[1], m[0], 16);
            drain_rx("modes");
            check_err("modes", 3'b111);
        end
    endtask

    task automatic test_underrun();
        mosi_words[0] = 8'($urandom);
        spi_frame(1'b0, 1'b0, 8);
        checks++;
        if (err_o !== 3'b010) begin
            errors++;
            $display("FAIL underrun_err: got %b expected 010", err_o);
        end
        drain_rx("underrun");
        check_err("underrun", 3'b010);
    endtask

    task automatic test_overrun();
        ie_i = 1'b1;
        for (int i = 0; i < 5; i++) push_tx(8'($urandom));
        for (int i = 0; i < 5; i++) mosi_words[i] = 8'($urandom);
        spi_frame(1'($urandom), 1'($urandom), 40);
        checks++;
        if (rx_level_o !== LVL_W'(DEPTH) || err_o[0] !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun: got lvl %0d err %b irq %b expected lvl 4 err0 1 irq 1",
                     rx_level_o, err_o, irq_o);
        end
        check_irq("overrun");
        drain_rx("overrun");
        check_err("overrun", 3'b111);
        ie_i = 1'b0;
    endtask

    task automatic test_abort();
        push_tx(8'($urandom));
        mosi_words[0] = 8'($urandom);
        spi_frame(1'($urandom), 1'($urandom), 3);
        checks++;
        if (rx_valid_o !== 1'b0 || err_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort: got rxv %b err %b expected rxv 0 err2 1", rx_valid_o, err_o);
        end
        check_err("abort", 3'b111);
        push_tx(8'($urandom));
        mosi_words[0] = 8'($urandom);
        spi_frame(1'($urandom), 1'($urandom), 8);
        drain_rx("after_abort");
        check_err("after_abort", 3'b111);
    endtask

    task automatic test_reset_mid();
        cpol_i = 1'b0;
        cpha_i = 1'b0;
        sclk_i = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        ss_n_i = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        for (int b = 0; b < 3; b++) begin
            mosi_i = 1'($urandom);
            repeat (HALF) @(negedge sys_clk);
            sclk_i = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            sclk_i = 1'b0;
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || rx_valid_o !== 1'b0 || tx_ready_o !== 1'b1 ||
            rx_level_o !== '0 || err_o !== 3'b000 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got miso=%b oe=%b rxv=%b txr=%b lvl=%0d err=%b irq=%b expected 0 0 0 1 0 000 0",
                     miso_o, miso_oe_o, rx_valid_o, tx_ready_o, rx_level_o, err_o, irq_o);
        end
        sys_rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        err_m = 3'b000;
        // ss_n still low: clocks here must not start a frame.
        for (int b = 0; b < 8; b++) begin
            mosi_i = 1'($urandom);
            repeat (HALF) @(negedge sys_clk);
            sclk_i = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            sclk_i = 1'b0;
        end
        checks++;
        if (miso_oe_o !== 1'b0 || rx_level_o !== '0 || err_o !== 3'b000) begin
            errors++;
            $display("FAIL no_frame_after_reset: got oe=%b lvl=%0d err=%b expected 0 0 000",
                     miso_oe_o, rx_level_o, err_o);
        end
        ss_n_i = 1'b1;
        repeat (8) @(negedge sys_clk);
        push_tx(8'($urandom));
        mosi_words[0] = 8'($urandom);
        spi_frame(1'b0, 1'b0, 8);
        drain_rx("post_reset");
        check_err("post_reset", 3'b111);
    endtask

    task automatic test_random();
        int np;
        int nw;
        for (int f = 0; f < 12; f++) begin
            ie_i = 1'($urandom);
            np = $urandom_range(0, 5);
            nw = $urandom_range(1, 3);
            for (int i = 0; i < np; i++) push_tx(8'($urandom));
            for (int i = 0; i < nw; i++) mosi_words[i] = 8'($urandom);
            spi_frame(1'($urandom), 1'($urandom), nw * DW);
            check_irq("random");
            drain_rx("random");
            check_err("random", 3'b111);
        end
        ie_i = 1'b0;
    endtask

    initial begin
        sys_rst    = 1'b1;
        sclk_i     = 1'b0;
        mosi_i     = 1'b0;
        ss_n_i     = 1'b1;
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        ie_i       = 1'b0;
        rx_ready_i = 1'b0;
        tx_data_i  = '0;
        tx_valid_i = 1'b0;
        err_clr_i  = 3'b000;
        err_m      = 3'b000;
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
